// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code arbiter slice.
// Holds default sizes and the width-generic XOR-shift conversion.
package gray_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int NREQ_DEF  = 4;

   // Widest code the shared conversion function handles.
   localparam int GRAY_MAXW = 64;

   // Callers zero-extend into the wide argument and keep the low bits.
   function automatic logic [GRAY_MAXW-1:0] gray_of(
      input logic [GRAY_MAXW-1:0] bin
   );
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/bin2gray.sv
// Pure combinational binary-to-Gray converter, WIDTH bits (WIDTH < 64).
// The high bits of the wide helper result are always zero and discarded.
module bin2gray
   import gray_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] bin_i,
   output logic [WIDTH-1:0] gray_o
);

   logic [GRAY_MAXW-WIDTH-1:0] unused_hi;

   assign {unused_hi, gray_o} = gray_of(GRAY_MAXW'(bin_i));

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one bin2gray converter among NREQ requesters.
// Optional macro GRAY_ARB_PARITY_EN adds a registered out_parity output.
module gray_conv_arbiter
   import gray_pkg::*;
#(
   parameter  int WIDTH = WIDTH_DEF,
   parameter  int NREQ  = NREQ_DEF,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_bin,
   output logic [NREQ-1:0]       req_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_gray,
   output logic [WIDTH-1:0]      out_bin,
`ifdef GRAY_ARB_PARITY_EN
   output logic [IDW-1:0]        out_id,
   output logic                  out_parity
`else
   output logic [IDW-1:0]        out_id
`endif
);

   logic [IDW-1:0]   rr_q, rr_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic [IDW-1:0]   id_q, id_d;

   logic             slot_free;
   logic             gnt_found;
   logic             gnt_ok;
   logic [IDW-1:0]   gnt_idx;
   int               idx;
   logic [WIDTH-1:0] sel_bin;
   logic [WIDTH-1:0] sel_gray;

   // Slot can take a new result when empty or being drained this cycle.
   assign slot_free = ~valid_q | out_ready;

   // Scan from the slot after the last winner, wrapping, first valid wins.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      idx       = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(rr_q) + k) % NREQ;
         if (!gnt_found && req_valid[idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = IDW'(idx);
         end
      end
   end

   // Grant only into a free slot and never while reset is applied.
   assign gnt_ok = gnt_found & slot_free & ~rst;

   // Ready is the one-hot grant vector, or zero when nothing is granted.
   always_comb begin
      req_ready = '0;
      if (gnt_ok) begin
         req_ready[gnt_idx] = 1'b1;
      end
   end

   assign sel_bin = req_bin[int'(gnt_idx)*WIDTH +: WIDTH];

   bin2gray #(
      .WIDTH (WIDTH)
   ) u_b2g (
      .bin_i  (sel_bin),
      .gray_o (sel_gray)
   );

   // Output slot and fairness pointer next state.
   always_comb begin
      valid_d = valid_q;
      gray_d  = gray_q;
      bin_d   = bin_q;
      id_d    = id_q;
      rr_d    = rr_q;
      if (gnt_ok) begin
         valid_d = 1'b1;
         gray_d  = sel_gray;
         bin_d   = sel_bin;
         id_d    = gnt_idx;
         rr_d    = gnt_idx;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   // Register the slot; reset drops any in-flight result.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         gray_q  <= '0;
         bin_q   <= '0;
         id_q    <= '0;
         rr_q    <= IDW'(NREQ-1);
      end else begin
         valid_q <= valid_d;
         gray_q  <= gray_d;
         bin_q   <= bin_d;
         id_q    <= id_d;
         rr_q    <= rr_d;
      end
   end

   assign out_valid = valid_q;
   assign out_gray  = gray_q;
   assign out_bin   = bin_q;
   assign out_id    = id_q;

`ifdef GRAY_ARB_PARITY_EN
   logic parity_q, parity_d;

   assign parity_d = gnt_ok ? ^sel_gray : parity_q;

   // Parity travels with the data it covers.
   always_ff @(posedge clk) begin
      if (rst) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end

   assign out_parity = parity_q;
`endif

endmodule
